// File: rtl/board_square_query_pkg.sv
// -----------------------------------------------------------------------------
// board_square_query_pkg
// Shared constants and types for the board square query block.
//   - slot geometry (6-bit locations, 16 slots per color, 96-bit vectors)
//   - piece-number encoding (slot index of each piece)
//   - colour encoding (BLACK=0, WHITE=1)
//   - initial white/black location vectors
//   - query FSM state type
// -----------------------------------------------------------------------------
package board_square_query_pkg;

  localparam int SLOT_W = 6;
  localparam int SLOT_N = 16;
  localparam int VEC_W  = SLOT_W * SLOT_N;

  localparam logic COLOR_BLACK = 1'b0;
  localparam logic COLOR_WHITE = 1'b1;

  // Piece number equals the slot index inside a location vector.
  localparam logic [3:0] PIECE_K1 = 4'd0;
  localparam logic [3:0] PIECE_Q1 = 4'd1;
  localparam logic [3:0] PIECE_B2 = 4'd2;
  localparam logic [3:0] PIECE_B1 = 4'd3;
  localparam logic [3:0] PIECE_N2 = 4'd4;
  localparam logic [3:0] PIECE_N1 = 4'd5;
  localparam logic [3:0] PIECE_R2 = 4'd6;
  localparam logic [3:0] PIECE_R1 = 4'd7;
  localparam logic [3:0] PIECE_P8 = 4'd8;
  localparam logic [3:0] PIECE_P7 = 4'd9;
  localparam logic [3:0] PIECE_P6 = 4'd10;
  localparam logic [3:0] PIECE_P5 = 4'd11;
  localparam logic [3:0] PIECE_P4 = 4'd12;
  localparam logic [3:0] PIECE_P3 = 4'd13;
  localparam logic [3:0] PIECE_P2 = 4'd14;
  localparam logic [3:0] PIECE_P1 = 4'd15;

  localparam logic [VEC_W-1:0] INIT_LOC_W = 96'h20928B30D38F0070460850C4;
  localparam logic [VEC_W-1:0] INIT_LOC_B = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  // Last scan counter value: black slot 0.
  localparam logic [4:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/board_slot_select.sv
// -----------------------------------------------------------------------------
// board_slot_select
// Combinational extraction of one slot from a packed location vector.
//   loc_vec   : 96-bit packed locations, slot i at [6i+5:6i]
//   alive_vec : 16-bit alive flags, bit i for slot i
//   idx       : slot index 0..15
//   loc       : 6-bit location of slot idx
//   alive     : alive flag of slot idx
// -----------------------------------------------------------------------------
module board_slot_select
  import board_square_query_pkg::*;
(
  input  logic [VEC_W-1:0]  loc_vec,
  input  logic [SLOT_N-1:0] alive_vec,
  input  logic [3:0]        idx,
  output logic [SLOT_W-1:0] loc,
  output logic              alive
);

  // Base bit of the selected slot; 7 bits covers the highest base (90).
  logic [6:0] base_s;

  assign base_s = 7'(idx) * 7'(SLOT_W);
  assign loc    = loc_vec[base_s +: SLOT_W];
  assign alive  = alive_vec[idx];

endmodule

// File: rtl/board_square_query.sv
// -----------------------------------------------------------------------------
// board_square_query
// Looks up which alive piece (if any) occupies a board square by scanning all
// 32 slots one per cycle from a snapshot taken when the request is accepted.
// Scan order: white slots 15..0, then black slots 15..0; the first hit sets
// the result, any further hit only raises conflict. Fixed 34-cycle latency.
//   clk                : rising-edge clock
//   RST                : synchronous active-low reset
//   en                 : request strobe, sampled only in IDLE
//   square             : square to look up (0..63)
//   location_vectors_w : white slot locations (96 bits)
//   location_vectors_b : black slot locations (96 bits)
//   alive_vectors_w    : white alive flags
//   alive_vectors_b    : black alive flags
//   busy               : state is not IDLE
//   done               : one-cycle result-valid pulse
//   occupied           : an alive piece sits on the square
//   color              : owner of found piece (BLACK=0, WHITE=1)
//   piece_number       : slot index of found piece
//   conflict           : more than one alive piece on the square
// -----------------------------------------------------------------------------
module board_square_query
  import board_square_query_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic              en,
  input  logic [5:0]        square,
  input  logic [VEC_W-1:0]  location_vectors_w,
  input  logic [VEC_W-1:0]  location_vectors_b,
  input  logic [SLOT_N-1:0] alive_vectors_w,
  input  logic [SLOT_N-1:0] alive_vectors_b,
  output logic              busy,
  output logic              done,
  output logic              occupied,
  output logic              color,
  output logic [3:0]        piece_number,
  output logic              conflict
);

  state_e              state_r, state_next_s;
  logic [4:0]          cnt_r, cnt_next_s;
  logic [5:0]          square_r, square_next_s;
  logic [VEC_W-1:0]    loc_w_r, loc_w_next_s, loc_b_r, loc_b_next_s;
  logic [SLOT_N-1:0]   alive_w_r, alive_w_next_s, alive_b_r, alive_b_next_s;
  logic                busy_r, busy_next_s;
  logic                done_r, done_next_s;
  logic                occupied_r, occupied_next_s;
  logic                color_r, color_next_s;
  logic [3:0]          piece_r, piece_next_s;
  logic                conflict_r, conflict_next_s;

  logic [VEC_W-1:0]    slot_vec_s;
  logic [SLOT_N-1:0]   slot_alive_vec_s;
  logic [3:0]          slot_idx_s;
  logic [SLOT_W-1:0]   slot_loc_s;
  logic                slot_alive_s;
  logic                hit_s;

  // Counter bit 4 picks the colour; the low bits count slots downward.
  assign slot_vec_s       = cnt_r[4] ? loc_b_r : loc_w_r;
  assign slot_alive_vec_s = cnt_r[4] ? alive_b_r : alive_w_r;
  assign slot_idx_s       = ~cnt_r[3:0];

  board_slot_select u_slot_select (
    .loc_vec   (slot_vec_s),
    .alive_vec (slot_alive_vec_s),
    .idx       (slot_idx_s),
    .loc       (slot_loc_s),
    .alive     (slot_alive_s)
  );

  assign hit_s = slot_alive_s && (slot_loc_s == square_r);

  // Next-state and next-result logic for the query FSM.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    square_next_s   = square_r;
    loc_w_next_s    = loc_w_r;
    loc_b_next_s    = loc_b_r;
    alive_w_next_s  = alive_w_r;
    alive_b_next_s  = alive_b_r;
    done_next_s     = 1'b0;
    occupied_next_s = occupied_r;
    color_next_s    = color_r;
    piece_next_s    = piece_r;
    conflict_next_s = conflict_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          square_next_s   = square;
          loc_w_next_s    = location_vectors_w;
          loc_b_next_s    = location_vectors_b;
          alive_w_next_s  = alive_vectors_w;
          alive_b_next_s  = alive_vectors_b;
          occupied_next_s = 1'b0;
          color_next_s    = COLOR_BLACK;
          piece_next_s    = 4'd0;
          conflict_next_s = 1'b0;
          cnt_next_s      = 5'd0;
          state_next_s    = ST_SCAN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hit_s && occupied_r) begin
          conflict_next_s = 1'b1;
        end else if (hit_s) begin
          occupied_next_s = 1'b1;
          color_next_s    = cnt_r[4] ? COLOR_BLACK : COLOR_WHITE;
          piece_next_s    = slot_idx_s;
        end else begin
          occupied_next_s = occupied_r;
        end
        // Counter holds at its last value so it never wraps inside a scan.
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          cnt_next_s = cnt_r + 5'd1;
        end
      end
      ST_DONE: begin
        done_next_s  = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, snapshot and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      square_r   <= 6'd0;
      loc_w_r    <= '0;
      loc_b_r    <= '0;
      alive_w_r  <= '0;
      alive_b_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      occupied_r <= 1'b0;
      color_r    <= COLOR_BLACK;
      piece_r    <= 4'd0;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      square_r   <= square_next_s;
      loc_w_r    <= loc_w_next_s;
      loc_b_r    <= loc_b_next_s;
      alive_w_r  <= alive_w_next_s;
      alive_b_r  <= alive_b_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      occupied_r <= occupied_next_s;
      color_r    <= color_next_s;
      piece_r    <= piece_next_s;
      conflict_r <= conflict_next_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign occupied     = occupied_r;
  assign color        = color_r;
  assign piece_number = piece_r;
  assign conflict     = conflict_r;

endmodule
